// File: rtl/fifo_pkg.sv
// Shared defaults and pointer helpers for the asynchronous FIFO read side.
// Both the controller and the bench import these so they agree on sizes.
package fifo_pkg;

   localparam int DW_DEF      = 560;
   localparam int AW_DEF      = 4;
   localparam int RAM_LAT_DEF = 1;

   // Reflected binary Gray code; callers zero-extend into and truncate out of 32 bits.
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Output-buffer depth that covers the RAM pipeline plus one cycle of back-pressure slack.
   function automatic int buf_depth(input int ram_lat);
      return ram_lat + 2;
   endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// Small in-order output buffer holding words returned from the FIFO RAM.
// Depth need not be a power of two; pointers wrap explicitly at DEPTH-1.
module fifo_out_buf #(
   parameter int DW    = 560,
   parameter int DEPTH = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic [DW-1:0] i_data,
   input  logic          i_pop,
   output logic [DW-1:0] o_data,
   output logic          o_full,
   output logic          o_empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [DW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   // NOTE: the storage array has no reset; r_count alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of an asynchronous FIFO: drives the RAM read port
// and presents words through a credit-controlled valid/ready output buffer.
module fifo_rd_ctrl
   import fifo_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int AW      = AW_DEF,
   parameter int RAM_LAT = RAM_LAT_DEF
) (
   input  logic          r_clk,
   input  logic          r_rst,
   input  logic [AW:0]   wptr_gray_sync,
   output logic          r_empty,
   output logic [AW:0]   r_addr,
   output logic [AW:0]   rptr_gray,
   output logic          en_ram,
   input  logic [DW-1:0] r_data,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready
);

   localparam int BUF_DEPTH = buf_depth(RAM_LAT);
   localparam int CW        = $clog2(BUF_DEPTH + 1);
   localparam logic [CW-1:0] CREDIT_INIT = CW'(BUF_DEPTH);

   logic [AW:0]        r_bin;
   logic [CW-1:0]      r_credit;
   logic [RAM_LAT-1:0] r_vld;

   logic        w_issue;
   logic        w_push;
   logic        w_pop;
   logic        w_buf_full;
   logic        w_buf_empty;
   logic [AW:0] w_bin_next;
   logic [AW:0] w_gray_next;

   // Credit counts free buffer slots not already promised to an in-flight read,
   // so a read is only launched when its data is guaranteed somewhere to land.
   assign w_issue     = ~r_empty & (r_credit != '0);
   assign w_bin_next  = r_bin + (AW + 1)'(w_issue);
   assign w_gray_next = (AW + 1)'(bin2gray(32'(w_bin_next)));
   assign w_push      = r_vld[RAM_LAT-1];
   assign w_pop       = ~w_buf_empty & out_ready;

   assign en_ram    = w_issue;
   assign r_addr    = r_bin;
   assign out_valid = ~w_buf_empty;

   always_ff @(posedge r_clk) begin
      if (r_rst) begin
         r_bin     <= '0;
         rptr_gray <= '0;
         r_empty   <= 1'b1;
         r_credit  <= CREDIT_INIT;
         r_vld     <= '0;
      end else begin
         r_bin     <= w_bin_next;
         rptr_gray <= w_gray_next;
         r_empty   <= (w_gray_next == wptr_gray_sync);
         r_vld     <= RAM_LAT'({r_vld, w_issue});
         case ({w_issue, w_pop})
            2'b10:   r_credit <= r_credit - 1'b1;
            2'b01:   r_credit <= r_credit + 1'b1;
            default: r_credit <= r_credit;
         endcase
      end
   end

   fifo_out_buf #(
      .DW    (DW),
      .DEPTH (BUF_DEPTH)
   ) u_out_buf (
      .clk     (r_clk),
      .rst     (r_rst),
      .i_push  (w_push),
      .i_data  (r_data),
      .i_pop   (w_pop),
      .o_data  (out_data),
      .o_full  (w_buf_full),
      .o_empty (w_buf_empty)
   );

   a_no_overflow: assert property (@(posedge r_clk) disable iff (r_rst) !(w_push && w_buf_full));

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: RAM_LAT=1 and RAM_LAT=2 instances share stimulus,
// each checked every cycle against a queue-based model of the read side.
module tb_fifo_rd_ctrl;
   import fifo_pkg::*;

   localparam int DW    = DW_DEF;
   localparam int AW    = AW_DEF;
   localparam int DEPTH = 1 << AW;
   localparam int PTRM  = 1 << (AW + 1);

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [AW:0] wptr = '0;
   logic        ready = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] mem [DEPTH];
   int            mem_tag [DEPTH];
   int            wcount = 0;
   int            seq = 0;

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] word_of(input int tag);
      logic [31:0]   v;
      logic [DW-1:0] w;
      v = 32'(tag) * 32'h9E37_79B1 + 32'h0BAD_F00D;
      for (int k = 0; k < DW; k++) w[k] = v[k % 32] ^ ((k / 32) % 2 == 1);
      return w;
   endfunction

   function automatic int gray_of(input int b);
      return b ^ (b >> 1);
   endfunction

   task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int LAT = g + 1;
      localparam int BD  = LAT + 2;

      logic [AW:0]   r_addr;
      logic [AW:0]   rptr_gray;
      logic          r_empty;
      logic          en_ram;
      logic          out_valid;
      logic [DW-1:0] r_data;
      logic [DW-1:0] out_data;
      logic [DW-1:0] s1;
      logic [DW-1:0] s2;

      fifo_rd_ctrl #(.DW(DW), .AW(AW), .RAM_LAT(LAT)) dut (
         .r_clk          (clk),
         .r_rst          (rst),
         .wptr_gray_sync (wptr),
         .r_empty        (r_empty),
         .r_addr         (r_addr),
         .rptr_gray      (rptr_gray),
         .en_ram         (en_ram),
         .r_data         (r_data),
         .out_data       (out_data),
         .out_valid      (out_valid),
         .out_ready      (ready)
      );

      // RAM port B: registered read, optional second output stage.
      always @(posedge clk) begin
         if (en_ram === 1'b1) s1 <= mem[r_addr[AW-1:0]];
         s2 <= s1;
      end
      assign r_data = (LAT == 1) ? s1 : s2;

      // Model: counts and queues of tags; a read may start whenever the FIFO is
      // non-empty and in-flight plus buffered words leave room in the buffer.
      bit m_live = 1'b0;
      bit m_empty;
      int m_rbin;
      int m_popped;
      int fly_tag[$];
      int fly_rem[$];
      int buf_q[$];

      always @(posedge clk) begin : p_model
         bit iss;
         bit pp;
         iss = m_live && !m_empty && (fly_tag.size() + buf_q.size() < BD);
         pp  = m_live && (buf_q.size() > 0) && (ready == 1'b1);
         if (rst == 1'b1) begin
            m_live   = 1'b1;
            m_empty  = 1'b1;
            m_rbin   = 0;
            m_popped = 0;
            fly_tag.delete();
            fly_rem.delete();
            buf_q.delete();
         end else if (m_live) begin
            if (pp) begin
               void'(buf_q.pop_front());
               m_popped++;
            end
            foreach (fly_rem[i]) fly_rem[i]--;
            while (fly_rem.size() > 0 && fly_rem[0] == 0) begin
               buf_q.push_back(fly_tag.pop_front());
               void'(fly_rem.pop_front());
            end
            if (iss) begin
               fly_tag.push_back(mem_tag[m_rbin % DEPTH]);
               fly_rem.push_back(LAT);
               m_rbin = (m_rbin + 1) % PTRM;
            end
            m_empty = ((wcount % PTRM) == m_rbin);
         end
      end

      int mon_en   = 0;
      int mon_pop  = 0;
      int next_tag = 0;

      always @(negedge clk) begin : p_cmp
         bit exp_iss;
         if (rst == 1'b1) begin
            mon_en   = 0;
            mon_pop  = 0;
            next_tag = seq;
         end
         if (m_live) begin
            exp_iss = !m_empty && (fly_tag.size() + buf_q.size() < BD);
            check($sformatf("L%0d en_ram", LAT), en_ram, exp_iss);
            check($sformatf("L%0d r_addr", LAT), r_addr, m_rbin);
            check($sformatf("L%0d r_empty", LAT), r_empty, m_empty);
            check($sformatf("L%0d rptr_gray", LAT), rptr_gray, gray_of(m_rbin));
            check($sformatf("L%0d out_valid", LAT), out_valid, buf_q.size() > 0);
            if (buf_q.size() > 0)
               check($sformatf("L%0d out_data", LAT), out_data, word_of(buf_q[0]));
            if (rst == 1'b0) begin
               if (en_ram === 1'b1) mon_en++;
               if (out_valid === 1'b1 && ready == 1'b1) begin
                  mon_pop++;
                  check($sformatf("L%0d order", LAT), out_data, word_of(next_tag));
                  next_tag++;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word();
      mem[wcount % DEPTH]     = word_of(seq);
      mem_tag[wcount % DEPTH] = seq;
      seq++;
      wcount++;
      wptr = (AW + 1)'(gray_of(wcount % PTRM));
   endtask

   task automatic do_reset();
      tick();
      rst    = 1'b1;
      wcount = 0;
      wptr   = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin : p_watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin : p_main
      int lat0;
      int lat1;
      int beats;
      int first;
      int last;
      int written;
      int tag0;
      bit done;

      // Reset state and single-word latency.
      do_reset();
      check("reset r_empty L1", g_inst[0].r_empty, 1'b1);
      check("reset out_valid L1", g_inst[0].out_valid, 1'b0);
      check("reset en_ram L2", g_inst[1].en_ram, 1'b0);
      check("reset rptr_gray L2", g_inst[1].rptr_gray, 0);
      ready = 1'b1;
      write_word();
      lat0 = -1;
      lat1 = -1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 1) begin
            check("r_empty low after 1 edge L1", g_inst[0].r_empty, 1'b0);
            check("r_empty low after 1 edge L2", g_inst[1].r_empty, 1'b0);
         end
         if (lat0 < 0 && g_inst[0].out_valid === 1'b1) lat0 = c;
         if (lat1 < 0 && g_inst[1].out_valid === 1'b1) lat1 = c;
      end
      check("latency L1", lat0, 3);
      check("latency L2", lat1, 4);
      check("single en_ram L1", g_inst[0].mon_en, 1);
      check("single pop L2", g_inst[1].mon_pop, 1);

      // Sixteen words streamed with out_ready held high.
      do_reset();
      ready = 1'b1;
      for (int i = 0; i < 16; i++) write_word();
      beats = 0;
      first = -1;
      last  = -1;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (g_inst[1].out_valid === 1'b1) begin
            beats++;
            if (first < 0) first = c;
            last = c;
         end
      end
      check("burst beats L2", beats, 16);
      check("burst no gaps L2", last - first + 1, 16);
      check("burst pops L1", g_inst[0].mon_pop, 16);
      check("burst rptr_gray L1", g_inst[0].rptr_gray, 5'b11000);
      check("burst r_empty L2", g_inst[1].r_empty, 1'b1);

      // Back-pressure: reads stop once the buffer and pipeline are full.
      do_reset();
      ready = 1'b0;
      tag0  = seq;
      for (int i = 0; i < 10; i++) write_word();
      repeat (20) tick();
      check("stall en_ram L1", g_inst[0].mon_en, 3);
      check("stall en_ram L2", g_inst[1].mon_en, 4);
      check("stall head L1", g_inst[0].out_data, word_of(tag0));
      repeat (10) tick();
      check("stall en_ram hold L1", g_inst[0].mon_en, 3);
      check("stall head hold L2", g_inst[1].out_data, word_of(tag0));
      ready = 1'b1;
      repeat (30) tick();
      check("release pops L1", g_inst[0].mon_pop, 10);
      check("release pops L2", g_inst[1].mon_pop, 10);
      check("release en_ram L2", g_inst[1].mon_en, 10);

      // Forty words through pointer wrap with random write pacing and back-pressure.
      do_reset();
      written = 0;
      done    = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
         ready = ($urandom_range(0, 3) != 0);
         if (written < 40 && $urandom_range(0, 2) != 0 &&
             (wcount - ((g_inst[0].m_popped < g_inst[1].m_popped) ?
                        g_inst[0].m_popped : g_inst[1].m_popped)) < DEPTH) begin
            write_word();
            written++;
         end
         tick();
         done = (g_inst[0].mon_pop == 40) && (g_inst[1].mon_pop == 40);
      end
      ready = 1'b1;
      check("wrap pops L1", g_inst[0].mon_pop, 40);
      check("wrap pops L2", g_inst[1].mon_pop, 40);
      check("wrap rptr_gray L2", g_inst[1].rptr_gray, 5'b01100);

      // Reset with reads in flight: returning data must be discarded.
      do_reset();
      ready = 1'b1;
      for (int i = 0; i < 8; i++) write_word();
      repeat (3) tick();
      rst    = 1'b1;
      wcount = 0;
      wptr   = '0;
      tick();
      check("midrst out_valid L1", g_inst[0].out_valid, 1'b0);
      check("midrst out_valid L2", g_inst[1].out_valid, 1'b0);
      check("midrst r_empty L2", g_inst[1].r_empty, 1'b1);
      rst = 1'b0;
      repeat (8) tick();
      check("midrst no stale L1", g_inst[0].mon_pop, 0);
      check("midrst no stale L2", g_inst[1].mon_pop, 0);
      write_word();
      repeat (10) tick();
      check("post-rst pop L1", g_inst[0].mon_pop, 1);
      check("post-rst pop L2", g_inst[1].mon_pop, 1);
      check("post-rst r_addr L2", g_inst[1].r_addr, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
